// File: rtl/booth_pkg.sv
// Shared radix-8 Booth micro-op encoding.
// Used by both the controller FSM and the datapath.
package booth_pkg;

   typedef logic [3:0] booth_op_t;

   localparam booth_op_t OP_NOP   = 4'd0;
   localparam booth_op_t OP_ADD_M = 4'd1;
   localparam booth_op_t OP_SUB_M = 4'd2;
   localparam booth_op_t OP_LOAD  = 4'd3;
   localparam booth_op_t OP_SHIFT = 4'd4;
   localparam booth_op_t OP_ADD2M = 4'd5;
   localparam booth_op_t OP_SUB2M = 4'd6;
   localparam booth_op_t OP_ADD3M = 4'd7;
   localparam booth_op_t OP_SUB3M = 4'd8;
   localparam booth_op_t OP_SUB4M = 4'd9;
   localparam booth_op_t OP_ADD4M = 4'd10;

endpackage

// File: rtl/booth_addend_sel.sv
// Maps an add/sub micro-op to a signed AW-bit addend.
// The 3M multiple comes pre-computed so the op cycle has one adder.
module booth_addend_sel
   import booth_pkg::*;
#(
   parameter int N  = 8,
   parameter int AW = N + 4
) (
   input  logic [3:0]    si,
   input  logic [N-1:0]  m,
   input  logic [AW-1:0] m3,
   output logic [AW-1:0] addend,
   output logic          add_en
);

   logic [AW-1:0] mx;

   assign mx = AW'($signed(m));

   // Select +/-k*M for the current micro-op; anything else adds nothing
   always_comb begin
      addend = '0;
      add_en = 1'b0;
      case (si)
         OP_ADD_M: begin addend = mx;             add_en = 1'b1; end
         OP_SUB_M: begin addend = '0 - mx;        add_en = 1'b1; end
         OP_ADD2M: begin addend = mx << 1;        add_en = 1'b1; end
         OP_SUB2M: begin addend = '0 - (mx << 1); add_en = 1'b1; end
         OP_ADD3M: begin addend = m3;             add_en = 1'b1; end
         OP_SUB3M: begin addend = '0 - m3;        add_en = 1'b1; end
         OP_ADD4M: begin addend = mx << 2;        add_en = 1'b1; end
         OP_SUB4M: begin addend = '0 - (mx << 2); add_en = 1'b1; end
         default:  begin addend = '0;             add_en = 1'b0; end
      endcase
   end

endmodule

// File: rtl/booth_radix8_datapath.sv
// Radix-8 Booth multiplier datapath: accumulator, multiplier shift
// register and iteration counter, driven one micro-op per cycle.
module booth_radix8_datapath
   import booth_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic [3:0]     Si,
   input  logic           Count,
   input  logic [N-1:0]   Multiplicand,
   input  logic [N-1:0]   Multiplier,
   output logic [3:0]     B,
   output logic           Done,
   output logic [2*N-1:0] Product,
   output logic           Valid
);

   localparam int ITERS = (N + 2) / 3;
   localparam int L     = 3 * ITERS;
   localparam int AW    = N + 4;
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   logic [AW-1:0] a_q, a_d;
   logic [L-1:0]  q_q, q_d;
   logic          q1_q, q1_d;
   logic [N-1:0]  m_q, m_d;
   logic [AW-1:0] m3_q, m3_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          valid_q, valid_d;

   logic [AW-1:0] addend;
   logic          add_en;
   logic [AW-1:0] mc;
   logic signed [AW+L:0] cat_s;
   logic signed [AW+L:0] sh_s;

   booth_addend_sel #(
      .N  (N),
      .AW (AW)
   ) u_sel (
      .si     (Si),
      .m      (m_q),
      .m3     (m3_q),
      .addend (addend),
      .add_en (add_en)
   );

   assign mc    = AW'($signed(Multiplicand));
   assign cat_s = {a_q, q_q, q1_q};
   assign sh_s  = cat_s >>> 3;

   assign B       = {q_q[2:0], q1_q};
   assign Done    = busy_q & (cnt_q == LAST);
   assign Product = {a_q[2*N-L-1:0], q_q};
   assign Valid   = valid_q;

   // Next-state: LOAD restarts from anywhere; other ops act only while busy
   always_comb begin
      a_d     = a_q;
      q_d     = q_q;
      q1_d    = q1_q;
      m_d     = m_q;
      m3_d    = m3_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      if (Si == OP_LOAD) begin
         a_d     = '0;
         q_d     = L'($signed(Multiplier));
         q1_d    = 1'b0;
         m_d     = Multiplicand;
         m3_d    = mc + (mc << 1);
         cnt_d   = '0;
         busy_d  = 1'b1;
         valid_d = 1'b0;
      end else if (busy_q) begin
         if (add_en) begin
            a_d = a_q + addend;
         end else if (Si == OP_SHIFT) begin
            a_d  = sh_s[AW+L:L+1];
            q_d  = sh_s[L:1];
            q1_d = sh_s[0];
            if (Done) begin
               busy_d  = 1'b0;
               valid_d = 1'b1;
            end
         end
         if (Count && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         a_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         m_q     <= '0;
         m3_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         m_q     <= m_d;
         m3_q    <= m3_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

endmodule
